// File: rtl/tl_buffer_param.sv
// rtl/tl_buffer_param.sv - five-channel TileLink buffer built from independent parameterised FIFO queues
// Each channel has its own depth; FLOW adds empty-queue bypass, PIPE lets a full queue accept while draining.

module tl_buffer_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enq_valid,
  input  logic [WIDTH-1:0] i_enq_bits,
  output logic             o_enq_ready,
  output logic             o_deq_valid,
  output logic [WIDTH-1:0] o_deq_bits,
  input  logic             i_deq_ready
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign o_deq_valid = i_enq_valid;
      assign o_deq_bits  = i_enq_bits;
      assign o_enq_ready = i_deq_ready;
    end else begin : g_fifo
      localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam int CW = $clog2(DEPTH + 1);

      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [PW-1:0]    r_wptr;
      logic [PW-1:0]    r_rptr;
      logic [CW-1:0]    r_count;

      logic w_empty;
      logic w_full;
      logic w_do_enq;
      logic w_do_deq;
      logic w_bypass;
      logic w_wr;
      logic w_rd;

      assign w_empty = (r_count == '0);
      assign w_full  = (r_count == CW'(DEPTH));

      assign o_enq_ready = !w_full || ((PIPE != 0) && i_deq_ready);
      assign o_deq_valid = !w_empty || ((FLOW != 0) && i_enq_valid);
      assign o_deq_bits  = ((FLOW != 0) && w_empty) ? i_enq_bits : r_mem[r_rptr];

      assign w_do_enq = i_enq_valid && o_enq_ready;
      assign w_do_deq = o_deq_valid && i_deq_ready;
      // A beat that bypasses an empty queue leaves no trace in storage.
      assign w_bypass = (FLOW != 0) && w_empty && w_do_deq;
      assign w_wr     = w_do_enq && !w_bypass;
      assign w_rd     = w_do_deq && !w_bypass;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_count <= '0;
        end else begin
          if (w_wr) begin
            r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
          end
          if (w_rd) begin
            r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
          end
          if (w_wr && !w_rd) begin
            r_count <= r_count + 1'b1;
          end else if (!w_wr && w_rd) begin
            r_count <= r_count - 1'b1;
          end
        end
      end

      always_ff @(posedge clock) begin
        if (w_wr) begin
          r_mem[r_wptr] <= i_enq_bits;
        end
      end
    end
  endgenerate

endmodule

module tl_buffer_param #(
  parameter int A_DEPTH = 2,
  parameter int B_DEPTH = 2,
  parameter int C_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter int E_DEPTH = 2,
  parameter int FLOW    = 0,
  parameter int PIPE    = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_a_valid,
  input  logic [115:0] in_a_bits,
  output logic         in_a_ready,
  output logic         out_a_valid,
  output logic [115:0] out_a_bits,
  input  logic         out_a_ready,
  input  logic         out_b_valid,
  input  logic [51:0]  out_b_bits,
  output logic         out_b_ready,
  output logic         in_b_valid,
  output logic [51:0]  in_b_bits,
  input  logic         in_b_ready,
  input  logic         in_c_valid,
  input  logic [107:0] in_c_bits,
  output logic         in_c_ready,
  output logic         out_c_valid,
  output logic [107:0] out_c_bits,
  input  logic         out_c_ready,
  input  logic         out_d_valid,
  input  logic [79:0]  out_d_bits,
  output logic         out_d_ready,
  output logic         in_d_valid,
  output logic [79:0]  in_d_bits,
  input  logic         in_d_ready,
  input  logic         in_e_valid,
  input  logic [2:0]   in_e_bits,
  output logic         in_e_ready,
  output logic         out_e_valid,
  output logic [2:0]   out_e_bits,
  input  logic         out_e_ready
);

  // A, C, E flow client->manager; B, D flow manager->client.
  tl_buffer_queue #(.DEPTH(A_DEPTH), .WIDTH(116), .FLOW(FLOW), .PIPE(PIPE)) u_a (
    .clock(clock), .reset(reset),
    .i_enq_valid(in_a_valid), .i_enq_bits(in_a_bits), .o_enq_ready(in_a_ready),
    .o_deq_valid(out_a_valid), .o_deq_bits(out_a_bits), .i_deq_ready(out_a_ready)
  );

  tl_buffer_queue #(.DEPTH(B_DEPTH), .WIDTH(52), .FLOW(FLOW), .PIPE(PIPE)) u_b (
    .clock(clock), .reset(reset),
    .i_enq_valid(out_b_valid), .i_enq_bits(out_b_bits), .o_enq_ready(out_b_ready),
    .o_deq_valid(in_b_valid), .o_deq_bits(in_b_bits), .i_deq_ready(in_b_ready)
  );

  tl_buffer_queue #(.DEPTH(C_DEPTH), .WIDTH(108), .FLOW(FLOW), .PIPE(PIPE)) u_c (
    .clock(clock), .reset(reset),
    .i_enq_valid(in_c_valid), .i_enq_bits(in_c_bits), .o_enq_ready(in_c_ready),
    .o_deq_valid(out_c_valid), .o_deq_bits(out_c_bits), .i_deq_ready(out_c_ready)
  );

  tl_buffer_queue #(.DEPTH(D_DEPTH), .WIDTH(80), .FLOW(FLOW), .PIPE(PIPE)) u_d (
    .clock(clock), .reset(reset),
    .i_enq_valid(out_d_valid), .i_enq_bits(out_d_bits), .o_enq_ready(out_d_ready),
    .o_deq_valid(in_d_valid), .o_deq_bits(in_d_bits), .i_deq_ready(in_d_ready)
  );

  tl_buffer_queue #(.DEPTH(E_DEPTH), .WIDTH(3), .FLOW(FLOW), .PIPE(PIPE)) u_e (
    .clock(clock), .reset(reset),
    .i_enq_valid(in_e_valid), .i_enq_bits(in_e_bits), .o_enq_ready(in_e_ready),
    .o_deq_valid(out_e_valid), .o_deq_bits(out_e_bits), .i_deq_ready(out_e_ready)
  );

endmodule

// File: tb/tb_tl_buffer_param.sv
// tb/tb_tl_buffer_param.sv - random and directed checks of two tl_buffer_param configurations against a queue model

module tb_tl_buffer_param;

  logic         clock;
  logic         reset;
  logic [4:0]   ev;
  logic [115:0] eb [5];
  logic [4:0]   dr;
  wire  [4:0]   er0, er1, dv0, dv1;
  wire  [115:0] o0a, o1a;
  wire  [51:0]  o0b, o1b;
  wire  [107:0] o0c, o1c;
  wire  [79:0]  o0d, o1d;
  wire  [2:0]   o0e, o1e;

  int total = 0;
  int bad   = 0;
  bit run   = 0;

  logic [115:0] mq   [2][5][8];
  int           mcnt [2][5];
  bit           fenq [2][5];
  bit           fdeq [2][5];

  tl_buffer_param #(.A_DEPTH(2), .B_DEPTH(4), .C_DEPTH(1), .D_DEPTH(0), .E_DEPTH(2),
                    .FLOW(0), .PIPE(0)) u0 (
    .clock(clock), .reset(reset),
    .in_a_valid(ev[0]), .in_a_bits(eb[0]), .in_a_ready(er0[0]),
    .out_a_valid(dv0[0]), .out_a_bits(o0a), .out_a_ready(dr[0]),
    .out_b_valid(ev[1]), .out_b_bits(eb[1][51:0]), .out_b_ready(er0[1]),
    .in_b_valid(dv0[1]), .in_b_bits(o0b), .in_b_ready(dr[1]),
    .in_c_valid(ev[2]), .in_c_bits(eb[2][107:0]), .in_c_ready(er0[2]),
    .out_c_valid(dv0[2]), .out_c_bits(o0c), .out_c_ready(dr[2]),
    .out_d_valid(ev[3]), .out_d_bits(eb[3][79:0]), .out_d_ready(er0[3]),
    .in_d_valid(dv0[3]), .in_d_bits(o0d), .in_d_ready(dr[3]),
    .in_e_valid(ev[4]), .in_e_bits(eb[4][2:0]), .in_e_ready(er0[4]),
    .out_e_valid(dv0[4]), .out_e_bits(o0e), .out_e_ready(dr[4])
  );

  tl_buffer_param #(.A_DEPTH(4), .B_DEPTH(4), .C_DEPTH(1), .D_DEPTH(0), .E_DEPTH(2),
                    .FLOW(1), .PIPE(1)) u1 (
    .clock(clock), .reset(reset),
    .in_a_valid(ev[0]), .in_a_bits(eb[0]), .in_a_ready(er1[0]),
    .out_a_valid(dv1[0]), .out_a_bits(o1a), .out_a_ready(dr[0]),
    .out_b_valid(ev[1]), .out_b_bits(eb[1][51:0]), .out_b_ready(er1[1]),
    .in_b_valid(dv1[1]), .in_b_bits(o1b), .in_b_ready(dr[1]),
    .in_c_valid(ev[2]), .in_c_bits(eb[2][107:0]), .in_c_ready(er1[2]),
    .out_c_valid(dv1[2]), .out_c_bits(o1c), .out_c_ready(dr[2]),
    .out_d_valid(ev[3]), .out_d_bits(eb[3][79:0]), .out_d_ready(er1[3]),
    .in_d_valid(dv1[3]), .in_d_bits(o1d), .in_d_ready(dr[3]),
    .in_e_valid(ev[4]), .in_e_bits(eb[4][2:0]), .in_e_ready(er1[4]),
    .out_e_valid(dv1[4]), .out_e_bits(o1e), .out_e_ready(dr[4])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int wid(int c);
    case (c)
      0: return 116;
      1: return 52;
      2: return 108;
      3: return 80;
      default: return 3;
    endcase
  endfunction

  function automatic int dep(int k, int c);
    case (c)
      0: return (k == 1) ? 4 : 2;
      1: return 4;
      2: return 1;
      3: return 0;
      default: return 2;
    endcase
  endfunction

  function automatic logic [115:0] wmask(int c);
    logic [115:0] m;
    m = '1;
    return m >> (116 - wid(c));
  endfunction

  function automatic logic [115:0] obits(int k, int c);
    case (c)
      0: return (k == 1) ? o1a : o0a;
      1: return {64'b0, (k == 1) ? o1b : o0b};
      2: return {8'b0, (k == 1) ? o1c : o0c};
      3: return {36'b0, (k == 1) ? o1d : o0d};
      default: return {113'b0, (k == 1) ? o1e : o0e};
    endcase
  endfunction

  function automatic logic [115:0] a_addr(logic [31:0] ad);
    return {12'h0, ad, 72'h0};
  endfunction

  function automatic logic [115:0] rnd116();
    return 116'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic chk(string nm, logic [115:0] act, logic [115:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Expected outputs come from the queue contents alone: head of list, occupancy versus depth.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 5; c++) begin
        if (reset && run) begin
          int n;
          int cnt;
          logic xv, xr;
          logic [115:0] xb;
          n   = dep(k, c);
          cnt = mcnt[k][c];
          if (n == 0) begin
            xv = ev[c];
            xb = eb[c];
            xr = dr[c];
          end else begin
            xv = (cnt > 0) || ((k == 1) && ev[c]);
            xb = (cnt > 0) ? mq[k][c][0] : eb[c];
            xr = (cnt < n) || ((k == 1) && (cnt == n) && dr[c]);
          end
          total++;
          if (((k == 1) ? dv1[c] : dv0[c]) !== xv) begin
            bad++;
            $display("FAIL deq_valid inst%0d ch%0d act=%b exp=%b", k, c,
                     (k == 1) ? dv1[c] : dv0[c], xv);
          end
          total++;
          if (((k == 1) ? er1[c] : er0[c]) !== xr) begin
            bad++;
            $display("FAIL enq_ready inst%0d ch%0d act=%b exp=%b", k, c,
                     (k == 1) ? er1[c] : er0[c], xr);
          end
          if (xv) begin
            total++;
            if (obits(k, c) !== (xb & wmask(c))) begin
              bad++;
              $display("FAIL deq_bits inst%0d ch%0d act=%h exp=%h", k, c, obits(k, c), xb & wmask(c));
            end
          end
          fenq[k][c] <= ev[c] && xr;
          fdeq[k][c] <= xv && dr[c];
        end else begin
          fenq[k][c] <= 1'b0;
          fdeq[k][c] <= 1'b0;
        end
      end
    end
  end

  always @(posedge clock or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 5; c++) begin
        if (!reset) begin
          mcnt[k][c] <= 0;
        end else if (dep(k, c) > 0) begin
          int cnt0;
          int pop;
          int push;
          cnt0 = mcnt[k][c];
          pop  = (fdeq[k][c] && cnt0 > 0) ? 1 : 0;
          push = (fenq[k][c] && !(cnt0 == 0 && fdeq[k][c])) ? 1 : 0;
          if (pop == 1) begin
            for (int i = 0; i < 7; i++) mq[k][c][i] <= mq[k][c][i+1];
          end
          if (push == 1) mq[k][c][cnt0 - pop] <= eb[c];
          mcnt[k][c] <= cnt0 - pop + push;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [115:0] cv1, cv2;
    int stall;
    reset = 1'b0;
    ev    = '0;
    dr    = '0;
    for (int c = 0; c < 5; c++) eb[c] = '0;
    #12;
    chk("rst_a_valid", 116'(dv0[0]), 116'(0));
    chk("rst_b_valid", 116'(dv0[1]), 116'(0));
    chk("rst_c_valid", 116'(dv0[2]), 116'(0));
    chk("rst_e_valid", 116'(dv0[4]), 116'(0));
    chk("rst_a_ready", 116'(er0[0]), 116'(1));
    chk("rst_b_ready", 116'(er0[1]), 116'(1));
    chk("rst_c_ready", 116'(er1[2]), 116'(1));
    chk("rst_e_ready", 116'(er1[4]), 116'(1));
    step();
    reset = 1'b1;
    run   = 1'b1;

    // two A beats held back by a stalled sink, then drained in order
    step();
    ev[0] = 1'b1; eb[0] = a_addr(32'h100);
    step();
    eb[0] = a_addr(32'h200);
    step();
    ev[0] = 1'b0; dr[0] = 1'b1;
    #2;
    chk("a_full_ready", 116'(er0[0]), 116'(0));
    chk("a_first_addr", 116'(o0a[103:72]), 116'h100);
    step();
    #2;
    chk("a_second_valid", 116'(dv0[0]), 116'(1));
    chk("a_second_addr", 116'(o0a[103:72]), 116'h200);
    step();
    #2;
    chk("a_drained", 116'(dv0[0]), 116'(0));
    dr[0] = 1'b0;

    // depth-0 D channel is a wire
    step();
    ev[3] = 1'b1; eb[3] = 116'(80'hDEAD << 1); dr[3] = 1'b1;
    #2;
    chk("d_pass_valid", 116'(dv0[3]), 116'(1));
    chk("d_pass_data", 116'(o0d[64:1]), 116'hDEAD);
    chk("d_pass_ready1", 116'(er0[3]), 116'(1));
    dr[3] = 1'b0;
    #1;
    chk("d_pass_ready0", 116'(er0[3]), 116'(0));
    ev[3] = 1'b0;

    // E bypass on u1, one-cycle latency on u0
    step();
    ev[4] = 1'b1; eb[4] = 116'(5); dr[4] = 1'b1;
    #2;
    chk("e_flow_valid", 116'(dv1[4]), 116'(1));
    chk("e_flow_sink", 116'(o1e), 116'(5));
    chk("e_noflow_valid", 116'(dv0[4]), 116'(0));
    step();
    ev[4] = 1'b0;
    #2;
    chk("e_flow_empty", 116'(dv1[4]), 116'(0));
    chk("e_noflow_sink", 116'(o0e), 116'(5));
    step();
    dr[4] = 1'b0;

    // full depth-1 C: PIPE accepts while draining, non-PIPE blocks
    cv1 = rnd116() & wmask(2);
    cv2 = rnd116() & wmask(2);
    ev[2] = 1'b1; eb[2] = cv1;
    step();
    eb[2] = cv2; dr[2] = 1'b1;
    #2;
    chk("c_pipe_ready", 116'(er1[2]), 116'(1));
    chk("c_nopipe_ready", 116'(er0[2]), 116'(0));
    chk("c_head_bits", 116'(o0c), cv1);
    step();
    ev[2] = 1'b0;
    #2;
    chk("c_pipe_holds", 116'(o1c), cv2);
    chk("c_nopipe_empty", 116'(dv0[2]), 116'(0));
    step();
    dr[2] = 1'b0;

    // reset with beats queued discards them
    ev[0] = 1'b1; eb[0] = a_addr(32'hA1);
    step();
    eb[0] = a_addr(32'hA2);
    step();
    eb[0] = a_addr(32'hA3);
    step();
    ev[0] = 1'b0;
    #2;
    chk("a_queued_valid", 116'(dv1[0]), 116'(1));
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_valid1", 116'(dv1[0]), 116'(0));
    chk("rst_mid_valid0", 116'(dv0[0]), 116'(0));
    step();
    step();
    reset = 1'b1;
    step();
    ev[0] = 1'b1; eb[0] = a_addr(32'h300); dr[0] = 1'b1;
    #2;
    chk("post_rst_flow_addr", 116'(o1a[103:72]), 116'h300);
    step();
    ev[0] = 1'b0;
    #2;
    chk("post_rst_addr", 116'(o0a[103:72]), 116'h300);
    step();
    dr[0] = 1'b0;

    // random traffic with shifting stall density and one mid-run reset
    stall = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if ((cyc % 250) == 0) stall = $urandom_range(0, 3);
      if (cyc == 1500) begin
        ev    = '0;
        reset = 1'b0;
        step();
        reset = 1'b1;
      end
      for (int c = 0; c < 5; c++) begin
        ev[c] = ($urandom_range(0, 3) >= 1);
        eb[c] = rnd116() & wmask(c);
        dr[c] = ($urandom_range(0, 3) >= 32'(stall));
      end
    end
    step();
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_buffer_param.md
TL_BUFFER_PARAM -- requirements
Module: tl_buffer_param

Interface
REQ-001 Parameter A_DEPTH, default 2: entries in the A-channel queue, range 0..8; 0 = combinational pass-through.
REQ-002 Parameter B_DEPTH, default 2: entries in the B-channel queue, range 0..8, same meaning.
REQ-003 Parameter C_DEPTH, default 2: entries in the C-channel queue, range 0..8, same meaning.
REQ-004 Parameter D_DEPTH, default 2: entries in the D-channel queue, range 0..8, same meaning.
REQ-005 Parameter E_DEPTH, default 2: entries in the E-channel queue, range 0..8, same meaning.
REQ-006 Parameter FLOW, default 0: 1 = an empty queue forwards enqueue data to its output in the same cycle.
REQ-007 Parameter PIPE, default 0: 1 = a full queue accepts enqueue in the same cycle it dequeues.
REQ-008 clock  input  1  single clock; all state changes on its rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 in_a_valid / in_a_bits  input  1 / 116; in_a_ready  output  1: A-channel request from the client.
REQ-011 out_a_valid / out_a_bits  output  1 / 116; out_a_ready  input  1: A-channel request to the manager.
REQ-012 out_b_valid / out_b_bits  input  1 / 52; out_b_ready  output  1: B-channel probe from the manager.
REQ-013 in_b_valid / in_b_bits  output  1 / 52; in_b_ready  input  1: B-channel probe to the client.
REQ-014 in_c_valid / in_c_bits  input  1 / 108; in_c_ready  output  1: C-channel release from the client.
REQ-015 out_c_valid / out_c_bits  output  1 / 108; out_c_ready  input  1: C-channel release to the manager.
REQ-016 out_d_valid / out_d_bits  input  1 / 80; out_d_ready  output  1: D-channel grant from the manager.
REQ-017 in_d_valid / in_d_bits  output  1 / 80; in_d_ready  input  1: D-channel grant to the client.
REQ-018 in_e_valid / in_e_bits  input  1 / 3; in_e_ready  output  1: E-channel sink ID from the client.
REQ-019 out_e_valid / out_e_bits  output  1 / 3; out_e_ready  input  1: E-channel sink ID to the manager.
REQ-020 Payload packing, MSB first: A = opcode3, param3, size4, source2, address32, mask8, data64; B = opcode3, param2, size4, source2, address32, mask8, corrupt1; C = opcode3, param3, size4, source2, address32, data64; D = opcode3, param2, size4, source2, sink3, denied1, data64, corrupt1; E = sink3.

Function
REQ-021 Every channel shall be an independent FIFO queue; no channel's state shall affect any other channel.
REQ-022 Depth-0 channel: valid, bits and ready shall be wired straight through, with no state and no latency.
REQ-023 Depth-N channel storage: N entries, a write pointer, a read pointer (both wrap N-1 -> 0), and a count 0..N.
REQ-024 Enqueue occurs when enq_valid && enq_ready; dequeue occurs when deq_valid && deq_ready; the count shall change by +1, -1, or 0 when both occur.
REQ-025 enq_ready shall be (count < N), or additionally deq_ready when PIPE=1 and count == N.
REQ-026 deq_valid shall be (count > 0), or additionally enq_valid when FLOW=1 and count == 0.
REQ-027 deq_bits shall be the entry at the read pointer; when FLOW=1 and count == 0 it shall be enq_bits.
REQ-028 FLOW bypass with a simultaneous dequeue: no entry shall be written, and neither pointers nor count shall change.
REQ-029 Latency at FLOW=0 shall be 1 cycle from enqueue to deq_valid; at FLOW=1 on an empty queue it shall be 0 cycles.
REQ-030 Order shall be strictly FIFO: no loss, duplication or reordering; bits shall be carried unmodified.
REQ-031 Full (count == N) with PIPE=0: enqueue shall be blocked even when a dequeue occurs in the same cycle.
REQ-032 N=1 with PIPE=0 and FLOW=0: maximum throughput shall be 1 beat every 2 cycles.
REQ-033 The sink shall be able to drop ready while valid is high; valid and bits shall then hold stable until the beat is accepted.

Reset
REQ-034 reset low shall asynchronously clear every count and pointer to 0; storage contents need not be cleared.
REQ-035 During reset: out_a/out_c/out_e/in_b/in_d valid shall be 0 for depth>0 channels; enq-side ready shall be 1.
REQ-036 Reset asserted mid-transfer shall discard all queued beats; the first post-reset dequeue shall be the first post-reset enqueue.

Verification
REQ-037 A_DEPTH=2: enqueue A beats with address 0x100 and 0x200 while out_a_ready=0 -> count=2, in_a_ready=0; raise out_a_ready -> 0x100 then 0x200 on consecutive cycles.
REQ-038 D_DEPTH=0: drive out_d_valid=1 with data 0xDEAD -> in_d_valid=1 and in_d_bits data=0xDEAD in the same cycle; in_d_ready propagates straight to out_d_ready.
REQ-039 FLOW=1, E_DEPTH=2, empty queue, out_e_ready=1: in_e_valid with sink=5 -> out_e_valid=1 and sink=5 in the same cycle; count stays 0.
REQ-040 PIPE=1, C_DEPTH=1, full queue, out_c_ready=1, in_c_valid=1 -> in_c_ready=1 and count stays 1; with PIPE=0 -> in_c_ready=0.
REQ-041 B_DEPTH=4: 10 beats with random stalls on both sides -> output order matches input order, and the pointers wrap correctly.
REQ-042 Assert reset with 3 beats queued in A -> out_a_valid=0 immediately; after release, a new beat 0x300 is the first output.
